// File: rtl/bpred_pkg.sv
// Shared types and counter helpers for the gshare/BTB branch predictor.
// Entry fields are sized for the widest supported address; unused upper bits stay zero.
package bpred_pkg;

  localparam int ADDR_MAX = 64;

  typedef enum logic [1:0] {
    BR  = 2'd0,
    JMP = 2'd1,
    RET = 2'd2
  } btb_type_t;

  typedef struct packed {
    logic                valid;
    logic [ADDR_MAX-1:0] tag;
    logic [ADDR_MAX-1:0] target;
    btb_type_t           btype;
  } btb_entry_t;

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt, input logic [2:0] max);
    return (cnt >= max) ? max : cnt + 3'd1;
  endfunction

  function automatic logic [2:0] sat_dec(input logic [2:0] cnt);
    return (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
  endfunction

endpackage

// File: rtl/bpred_ras.sv
// Circular return address stack: push on call, pop on return, oldest entry lost on overflow.
module bpred_ras
  import bpred_pkg::*;
#(
  parameter int RAS_DEPTH = 8,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_popped;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_popped;
  logic            pop_en;

  // Pop is applied first so a same-cycle call+ret replaces the top entry.
  assign pop_en       = pop && (count != '0);
  assign ptr_popped   = pop_en ? ptr - PW'(1) : ptr;
  assign count_popped = pop_en ? count - CW'(1) : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      ptr   <= ptr_popped;
      count <= count_popped;
      if (push) begin
        ptr                      <= ptr_popped + PW'(1);
        stack[ptr_popped + PW'(1)] <= push_data;
        count                    <= (count_popped == FULL) ? FULL : count_popped + CW'(1);
      end
    end
  end

  assign top   = stack[ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a tagged direct-mapped BTB, speculative GHR and a RAS.
// Lookup is combinational on fetch_pc; all training comes from resolved instructions.
module gshare_btb_predictor
  import bpred_pkg::*;
#(
  parameter int NFRAMES     = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int PRED_BITS   = 2,
  parameter int RAS_DEPTH   = 8,
  parameter int XLEN        = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                fetch_valid,
  input  logic [XLEN-1:0]     fetch_pc,
  output logic                predict_hit,
  output logic                predict_taken,
  output logic [XLEN-1:0]     predict_target,
  output logic [GHR_BITS-1:0] predict_ghr,
  input  logic                update_valid,
  input  logic [XLEN-1:0]     update_pc,
  input  logic                update_is_branch,
  input  logic                update_is_call,
  input  logic                update_is_ret,
  input  logic                update_taken,
  input  logic [XLEN-1:0]     update_target,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                update_mispredict
);

  localparam int BTB_IW = $clog2(NFRAMES);
  localparam int PHT_IW = $clog2(PHT_ENTRIES);
  localparam int TAG_W  = XLEN - 2 - BTB_IW;
  localparam logic [PRED_BITS-1:0] CNT_INIT = PRED_BITS'((1 << (PRED_BITS - 1)) - 1);
  localparam logic [PRED_BITS-1:0] CNT_MAX  = '1;

  btb_entry_t           btb [NFRAMES];
  logic [PRED_BITS-1:0] pht [PHT_ENTRIES];
  logic [GHR_BITS-1:0]  ghr;

  logic [BTB_IW-1:0]    f_idx, u_idx;
  logic [TAG_W-1:0]     f_tag, u_tag;
  logic [PHT_IW-1:0]    f_pidx, u_pidx;
  btb_entry_t           f_ent;
  logic [PRED_BITS-1:0] f_cnt;
  btb_type_t            u_type;
  logic                 ras_empty;
  logic [XLEN-1:0]      ras_top;
  logic                 unused_bits;

  assign f_idx  = fetch_pc[2 +: BTB_IW];
  assign f_tag  = fetch_pc[XLEN-1 -: TAG_W];
  assign f_pidx = fetch_pc[2 +: PHT_IW] ^ PHT_IW'(ghr);
  assign u_idx  = update_pc[2 +: BTB_IW];
  assign u_tag  = update_pc[XLEN-1 -: TAG_W];
  assign u_pidx = update_pc[2 +: PHT_IW] ^ PHT_IW'(update_ghr);
  assign f_ent  = btb[f_idx];
  assign f_cnt  = pht[f_pidx];

  assign predict_ghr = ghr;
  assign unused_bits = ^{fetch_pc[1:0], f_ent.target[ADDR_MAX-1:XLEN]};

  always_comb begin
    predict_hit    = f_ent.valid && (f_ent.tag == ADDR_MAX'(f_tag));
    predict_taken  = 1'b0;
    predict_target = '0;
    if (predict_hit) begin
      predict_target = f_ent.target[XLEN-1:0];
      case (f_ent.btype)
        BR:      predict_taken = f_cnt[PRED_BITS-1];
        RET: begin
          predict_taken = 1'b1;
          if (!ras_empty) predict_target = ras_top;
        end
        default: predict_taken = 1'b1;
      endcase
    end
  end

  always_comb begin
    u_type = JMP;
    if (update_is_ret)         u_type = RET;
    else if (update_is_branch) u_type = BR;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ghr <= '0;
      for (int i = 0; i < NFRAMES; i++)     btb[i].valid <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CNT_INIT;
    end else begin
      // A resolved mispredict rebuilds history from the fetch-time snapshot.
      if (update_valid && update_mispredict)
        ghr <= update_is_branch ? {update_ghr[GHR_BITS-2:0], update_taken} : update_ghr;
      else if (fetch_valid && predict_hit && (f_ent.btype == BR))
        ghr <= {ghr[GHR_BITS-2:0], predict_taken};
      if (update_valid && update_is_branch)
        pht[u_pidx] <= update_taken ? PRED_BITS'(sat_inc(3'(pht[u_pidx]), 3'(CNT_MAX)))
                                    : PRED_BITS'(sat_dec(3'(pht[u_pidx])));
      if (update_valid && update_taken)
        btb[u_idx] <= '{valid: 1'b1, tag: ADDR_MAX'(u_tag),
                        target: ADDR_MAX'(update_target), btype: u_type};
    end
  end

  bpred_ras #(.RAS_DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
    .clk       (CLK),
    .rst       (RST),
    .push      (update_valid && update_is_call),
    .pop       (update_valid && update_is_ret),
    .push_data (update_pc + XLEN'(4)),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor: directed vector table plus randomized traffic against a reference model.
module tb_gshare_btb_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic [7:0]  predict_ghr;
  logic        update_valid, update_is_branch, update_is_call, update_is_ret;
  logic        update_taken, update_mispredict;
  logic [31:0] update_pc, update_target;
  logic [7:0]  update_ghr;

  int checks = 0;
  int errors = 0;
  logic [41:0] exp_q[$];

  // uk: 0 none, 1 branch, 2 call, 3 ret, 4 jump, 5 call+ret
  typedef struct {
    bit fv; logic [31:0] fpc;
    int uk; logic [31:0] upc; bit ut; logic [31:0] utgt; logic [7:0] ughr; bit um;
    bit chk; bit hit; bit taken; logic [31:0] tgt; logic [7:0] ghr;
  } vec_t;

  vec_t tab[$];

  gshare_btb_predictor dut (
    .CLK(CLK), .RST(RST), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken),
    .predict_target(predict_target), .predict_ghr(predict_ghr),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_is_branch(update_is_branch), .update_is_call(update_is_call),
    .update_is_ret(update_is_ret), .update_taken(update_taken),
    .update_target(update_target), .update_ghr(update_ghr),
    .update_mispredict(update_mispredict)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain arrays and a queue for the return stack.
  bit          m_valid[64];
  int unsigned m_tag[64], m_tgt[64];
  int          m_kind[64];
  int          m_pht[256];
  int unsigned m_ghr;
  int unsigned ras_q[$];

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
    ras_q.delete();
  endtask

  task automatic model_predict(output bit hit, output bit taken, output int unsigned tgt);
    int i = int'(fetch_pc >> 2) % 64;
    hit = 0; taken = 0; tgt = 0;
    if (m_valid[i] && m_tag[i] == (fetch_pc >> 8)) begin
      hit = 1;
      tgt = m_tgt[i];
      if (m_kind[i] == 0) taken = m_pht[(int'(fetch_pc >> 2) % 256) ^ int'(m_ghr)] >= 2;
      else taken = 1;
      if (m_kind[i] == 2 && ras_q.size() > 0) tgt = ras_q[$];
    end
  endtask

  task automatic model_commit(input bit hit, input bit taken);
    int fi = int'(fetch_pc >> 2) % 64;
    int pi = (int'(update_pc >> 2) % 256) ^ int'(update_ghr);
    int ui = int'(update_pc >> 2) % 64;
    int unsigned ng = m_ghr;
    if (update_valid && update_mispredict)
      ng = update_is_branch ? ((int'(update_ghr) * 2) + int'(update_taken)) % 256 : update_ghr;
    else if (fetch_valid && hit && m_kind[fi] == 0)
      ng = ((m_ghr * 2) + int'(taken)) % 256;
    if (update_valid && update_is_branch) begin
      if (update_taken) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
      else              m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
    end
    if (update_valid && update_taken) begin
      m_valid[ui] = 1;
      m_tag[ui]   = update_pc >> 8;
      m_tgt[ui]   = update_target;
      m_kind[ui]  = update_is_ret ? 2 : (update_is_branch ? 0 : 1);
    end
    if (update_valid && update_is_ret && ras_q.size() > 0) void'(ras_q.pop_back());
    if (update_valid && update_is_call) ras_q.push_back(update_pc + 4);
    if (ras_q.size() > 8) void'(ras_q.pop_front());
    m_ghr = ng;
  endtask

  function automatic vec_t mk(bit fv, logic [31:0] fpc, int uk, logic [31:0] upc, bit ut,
                              logic [31:0] utgt, logic [7:0] ughr, bit um, bit chk,
                              bit hit, bit taken, logic [31:0] tgt, logic [7:0] ghr);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.uk = uk; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.ughr = ughr; v.um = um; v.chk = chk; v.hit = hit; v.taken = taken; v.tgt = tgt; v.ghr = ghr;
    return v;
  endfunction

  function automatic logic [31:0] pick_pc();
    int b = $urandom_range(0, 2);
    logic [31:0] base = (b == 0) ? 32'h0 : ((b == 1) ? 32'h100 : 32'h4000);
    return base + 32'(4 * $urandom_range(0, 15));
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = mk($urandom_range(0, 1), pick_pc(), $urandom_range(0, 5), pick_pc(), 1'b0,
           32'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0), 0, 0, 0, 0, 0);
    v.ut = (v.uk == 1) ? 1'($urandom_range(0, 1)) : (v.uk != 0);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    fetch_valid       = v.fv;
    fetch_pc          = v.fpc;
    update_valid      = (v.uk != 0);
    update_pc         = v.upc;
    update_is_branch  = (v.uk == 1);
    update_is_call    = (v.uk == 2) || (v.uk == 5);
    update_is_ret     = (v.uk == 3) || (v.uk == 5);
    update_taken      = v.ut;
    update_target     = v.utgt;
    update_ghr        = v.ughr;
    update_mispredict = v.um;
  endtask

  task automatic check(input string name, input int id, input logic [41:0] got, input logic [41:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got hit=%0b taken=%0b tgt=%h ghr=%h, want hit=%0b taken=%0b tgt=%h ghr=%h",
               name, id, got[41], got[40], got[39:8], got[7:0], exp[41], exp[40], exp[39:8], exp[7:0]);
    end
  endtask

  task automatic step(input vec_t v, input int id, input string name);
    bit e_hit, e_taken;
    int unsigned e_tgt;
    logic [41:0] got, exp;
    @(negedge CLK);
    apply(v);
    #2;
    model_predict(e_hit, e_taken, e_tgt);
    exp_q.push_back({e_hit, e_taken, 32'(e_tgt), 8'(m_ghr)});
    got = {predict_hit, predict_taken, predict_target, predict_ghr};
    exp = exp_q.pop_front();
    check({name, "_model"}, id, got, exp);
    if (v.chk) check(name, id, got, {v.hit, v.taken, v.tgt, v.ghr});
    @(posedge CLK);
    model_commit(e_hit, e_taken);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(idle);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;

    // Reset state, first allocation, counter saturation both ways.
    tab.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 'h100, 1, 'h100, 1, 'h80, 0, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h80, 0));
    tab.push_back(mk(0, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h80, 1));
    tab.push_back(mk(0, 'h100, 1, 'h100, 0, 'h80, 0, 1, 1, 1, 0, 'h80, 1));
    tab.push_back(mk(0, 'h100, 1, 'h100, 0, 'h80, 0, 0, 1, 1, 0, 'h80, 0));
    tab.push_back(mk(0, 'h100, 1, 'h100, 0, 'h80, 0, 0, 1, 1, 0, 'h80, 0));
    tab.push_back(mk(0, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h80, 0));
    for (int k = 0; k < 5; k++)
      tab.push_back(mk(0, 'h100, 1, 'h100, 1, 'h80, 0, 0, 1, 1, (k >= 2), 'h80, 0));
    tab.push_back(mk(0, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h80, 0));
    tab.push_back(mk(0, 'h100, 1, 'h100, 0, 'h80, 0, 0, 1, 1, 1, 'h80, 0));
    tab.push_back(mk(0, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h80, 0));
    // Train counters along the history path, then speculate GHR up to 0x07 and repair.
    tab.push_back(mk(0, 'h100, 1, 'h100, 1, 'h80, 'h01, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 'h100, 1, 'h100, 1, 'h80, 'h03, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h80, 'h00));
    tab.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h80, 'h01));
    tab.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h80, 'h03));
    tab.push_back(mk(1, 'h100, 1, 'h100, 0, 'h80, 'h01, 1, 1, 1, 0, 'h80, 'h07));
    tab.push_back(mk(0, 'h100, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h80, 'h02));
    // Return entry, RAS overflow, drain, underflow, call+ret replacement.
    tab.push_back(mk(0, 'h344, 3, 'h344, 1, 'h999, 0, 0, 1, 0, 0, 0, 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h999, 'h02));
    for (int k = 0; k < 9; k++)
      tab.push_back(mk(0, 'h344, 2, 32'h1000 + 32'(4 * k), 1, 'h2000, 0, 0, 1, 1, 1,
                       (k == 0) ? 32'h999 : 32'h1000 + 32'(4 * k), 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h1024, 'h02));
    for (int i = 0; i < 8; i++)
      tab.push_back(mk(0, 'h344, 3, 'h344, 1, 'h999, 0, 0, 1, 1, 1, 32'h1024 - 32'(4 * i), 'h02));
    tab.push_back(mk(0, 'h344, 3, 'h344, 1, 'h999, 0, 0, 1, 1, 1, 'h999, 'h02));
    tab.push_back(mk(0, 'h344, 2, 'h500, 1, 'h2000, 0, 0, 1, 1, 1, 'h999, 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h504, 'h02));
    tab.push_back(mk(0, 'h344, 3, 'h344, 1, 'h999, 0, 0, 1, 1, 1, 'h504, 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h999, 'h02));
    tab.push_back(mk(0, 'h344, 2, 'h101C, 1, 'h2000, 0, 0, 1, 1, 1, 'h999, 'h02));
    tab.push_back(mk(0, 'h344, 2, 'h1020, 1, 'h2000, 0, 0, 1, 1, 1, 'h1020, 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h1024, 'h02));
    tab.push_back(mk(0, 'h344, 5, 'h200, 1, 'h3000, 0, 0, 1, 1, 1, 'h1024, 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h204, 'h02));
    tab.push_back(mk(0, 'h344, 3, 'h344, 1, 'h999, 0, 0, 1, 1, 1, 'h204, 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h1020, 'h02));
    tab.push_back(mk(0, 'h344, 3, 'h344, 1, 'h999, 0, 0, 1, 1, 1, 'h1020, 'h02));
    tab.push_back(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h999, 'h02));

    for (int i = 0; i < tab.size(); i++) step(tab[i], i, "dir");

    for (int i = 0; i < 600; i++) step(rand_vec(), i, "rand");

    // Reset in the same cycle as a taken update must leave everything cleared.
    @(negedge CLK);
    apply(mk(1, 'h100, 1, 'h100, 1, 'h80, 'h05, 1, 0, 0, 0, 0, 0));
    RST = 1'b1;
    @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    apply(idle);
    step(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 0, "rst_mid");
    step(mk(0, 'h344, 3, 'h344, 1, 'h777, 0, 0, 1, 0, 0, 0, 0), 1, "rst_mid");
    step(mk(0, 'h344, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h777, 0), 2, "rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
